// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus joint 8-bit debounce for the two DIP-switch nibbles.
// A new {s1,s0} commits only after the synchronized word holds steady for the window.
module switch_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 24000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] raw_s0,
    input  logic [3:0] raw_s1,
    output logic [3:0] s0,
    output logic [3:0] s1,
    output logic       changed,
    output logic       settling
);

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       sync1_q;
    logic [7:0]       sync2_q;
    logic [7:0]       cand_q;
    logic [7:0]       cand_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       out_q;
    logic [7:0]       out_d;
    logic             changed_q;
    logic             changed_d;
    state_e           state_q;
    state_e           state_d;

    // Pure flop chain: nothing may sit between the two synchronizer stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {raw_s1, raw_s0};
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_q    <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            changed_q <= 1'b0;
            state_q   <= STABLE;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            changed_q <= changed_d;
            state_q   <= state_d;
        end
    end

    // Any bit change restarts the window for the whole word.
    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        changed_d = 1'b0;
        state_d   = state_q;
        if (sync2_q != cand_q) begin
            cand_d  = sync2_q;
            cnt_d   = '0;
            state_d = (sync2_q != out_q) ? SETTLING : STABLE;
        end else if (state_q == SETTLING && cnt_q == CNT_MAX) begin
            out_d     = cand_q;
            changed_d = 1'b1;
            state_d   = STABLE;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign s0       = out_q[3:0];
    assign s1       = out_q[7:4];
    assign changed  = changed_q;
    assign settling = (state_q == SETTLING);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer at a 4-cycle window.
// Table of per-edge vectors plus hand sequences for bounce and mid-window reset.
module tb_switch_debouncer;

    typedef struct {
        logic       rst_n;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] es0;
        logic [3:0] es1;
        logic       echg;
        logic       eset;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] raw_s0 = 4'h0;
    logic [3:0] raw_s1 = 4'h0;
    logic [3:0] s0;
    logic [3:0] s1;
    logic       changed;
    logic       settling;

    int nvec = 0;
    int nerr = 0;
    vec_t vq[$];

    switch_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .raw_s0   (raw_s0),
        .raw_s1   (raw_s1),
        .s0       (s0),
        .s1       (s1),
        .changed  (changed),
        .settling (settling)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] es0, input logic [3:0] es1,
                       input logic ec, input logic es, input int n);
        for (int i = 0; i < n; i++) vq.push_back('{r, a, b, es0, es1, ec, es});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] es0, input logic [3:0] es1,
                         input logic ec, input logic es, input logic use_set);
        nvec++;
        if (s0 !== es0 || s1 !== es1 || changed !== ec || (use_set && settling !== es)) begin
            nerr++;
            $display("FAIL %s: got s0=%h s1=%h chg=%b set=%b want s0=%h s1=%h chg=%b set=%b",
                     nm, s0, s1, changed, settling, es0, es1, ec, es);
        end
    endtask

    initial begin
        logic [4:0] sum;
        int pulses;

        add(0, 4'hF, 4'hA, 4'h0, 4'h0, 0, 0, 3);
        add(1, 4'hF, 4'hA, 4'h0, 4'h0, 0, 0, 2);
        add(1, 4'hF, 4'hA, 4'h0, 4'h0, 0, 1, 4);
        add(1, 4'hF, 4'hA, 4'hF, 4'hA, 1, 0, 1);
        add(1, 4'hF, 4'hA, 4'hF, 4'hA, 0, 0, 1);
        add(1, 4'h3, 4'h5, 4'hF, 4'hA, 0, 0, 2);
        add(1, 4'h3, 4'h5, 4'hF, 4'hA, 0, 1, 4);
        add(1, 4'h3, 4'h5, 4'h3, 4'h5, 1, 0, 1);
        add(1, 4'h3, 4'h5, 4'h3, 4'h5, 0, 0, 1);
        add(1, 4'h9, 4'h5, 4'h3, 4'h5, 0, 0, 2);
        add(1, 4'h9, 4'h5, 4'h3, 4'h5, 0, 1, 4);
        add(1, 4'h9, 4'h5, 4'h9, 4'h5, 1, 0, 1);
        add(1, 4'h9, 4'h5, 4'h9, 4'h5, 0, 0, 1);
        add(1, 4'h0, 4'h5, 4'h9, 4'h5, 0, 0, 2);
        add(1, 4'h0, 4'h5, 4'h9, 4'h5, 0, 1, 4);
        add(1, 4'h0, 4'h5, 4'h0, 4'h5, 1, 0, 1);
        add(1, 4'h0, 4'h5, 4'h0, 4'h5, 0, 0, 1);
        add(1, 4'h1, 4'h5, 4'h0, 4'h5, 0, 0, 1);
        add(1, 4'h0, 4'h5, 4'h0, 4'h5, 0, 0, 1);
        add(1, 4'h0, 4'h5, 4'h0, 4'h5, 0, 1, 1);
        add(1, 4'h0, 4'h5, 4'h0, 4'h5, 0, 0, 5);
        add(1, 4'hF, 4'hF, 4'h0, 4'h5, 0, 0, 2);
        add(1, 4'hF, 4'hF, 4'h0, 4'h5, 0, 1, 4);
        add(1, 4'hF, 4'hF, 4'hF, 4'hF, 1, 0, 1);
        add(1, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0, 1);
        add(1, 4'hF, 4'h0, 4'hF, 4'hF, 0, 0, 2);
        add(1, 4'hF, 4'hF, 4'hF, 4'hF, 0, 1, 2);
        add(1, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0, 5);

        #1;
        check("reset_t0", 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        foreach (vq[i]) begin
            reset  = vq[i].rst_n;
            raw_s0 = vq[i].a;
            raw_s1 = vq[i].b;
            step();
            check($sformatf("vec%0d", i), vq[i].es0, vq[i].es1, vq[i].echg, vq[i].eset, 1'b1);
        end

        sum = {1'b0, s0} + {1'b0, s1};
        nvec++;
        if (sum !== 5'h1E) begin
            nerr++;
            $display("FAIL adder_sum: got %h want 1e", sum);
        end

        for (int k = 0; k < 10; k++) begin
            raw_s1 = ((k / 2) % 2 == 0) ? 4'hB : 4'hF;
            step();
            check($sformatf("bounce_tog%0d", k), 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        end
        raw_s1 = 4'h4;
        pulses = 0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (changed) pulses++;
            if (e < 7)
                check($sformatf("bounce_hold%0d", e), 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
            else if (e == 7)
                check("bounce_commit", 4'hF, 4'h4, 1'b1, 1'b0, 1'b1);
            else
                check("bounce_after", 4'hF, 4'h4, 1'b0, 1'b0, 1'b1);
        end
        nvec++;
        if (pulses != 1) begin
            nerr++;
            $display("FAIL bounce_pulses: got %0d want 1", pulses);
        end

        raw_s0 = 4'h2;
        for (int e = 1; e <= 4; e++) step();
        check("midwin_pre", 4'hF, 4'h4, 1'b0, 1'b1, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("midwin_async", 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        nvec++;
        if (dut.cnt_q !== 2'd0) begin
            nerr++;
            $display("FAIL midwin_cnt: got %0d want 0", dut.cnt_q);
        end
        step();
        step();
        check("midwin_held", 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e < 3)
                check($sformatf("reacq%0d", e), 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
            else if (e < 7)
                check($sformatf("reacq%0d", e), 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
            else if (e == 7)
                check("reacq_commit", 4'h2, 4'h4, 1'b1, 1'b0, 1'b1);
            else
                check("reacq_after", 4'h2, 4'h4, 1'b0, 1'b0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
